// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, request/grant memory port with in-order
// responses, and a prefetch FIFO towards decode. Define FETCH_BYPASS_EN for the same-cycle response bypass.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvld,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_vld,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_rdy,
  output logic [XLEN-1:0] o_pc_debug,
  output logic            o_insn_vld
);

  localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam int unsigned   SW      = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc;
  cnt_t            outstanding;
  cnt_t            drop_cnt;
  cnt_t            count;
  cnt_t            wr_ptr, rd_ptr;
  cnt_t            tag_wr, tag_rd;

  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0] tag_q   [FIFO_DEPTH];

  logic [XLEN-1:0] pc_debug;
  logic            insn_vld;

  logic            grant, resp_drop, resp_cur;
  logic            fifo_empty, bypass, accept, push, pop;
  logic [SW-1:0]   in_use;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc, resp_pc;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^i_redirect_pc[1:0];

  // Pointers carry a wrap bit, so the difference is the occupancy including "full".
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);

  // Every in-flight or buffered word holds a credit, so the FIFO can never overflow.
  assign in_use      = SW'(count) + SW'(outstanding) + SW'(drop_cnt);
  assign o_imem_req  = ~i_reset & ~i_redirect & (in_use < DEPTH_S);
  assign o_imem_addr = fetch_pc;
  assign grant       = o_imem_req & i_imem_gnt;

  assign resp_drop = i_imem_rvld & (drop_cnt != '0);
  assign resp_cur  = i_imem_rvld & (drop_cnt == '0) & (outstanding != '0);
  assign resp_pc   = tag_q[tag_rd[AW-1:0]];

  assign head_instr = instr_q[rd_ptr[AW-1:0]];
  assign head_pc    = pc_q[rd_ptr[AW-1:0]];

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_cur & fifo_empty & ~i_redirect;
`else
  assign bypass = 1'b0;
`endif

  assign o_instr_vld = ~fifo_empty | bypass;
  assign o_instr     = bypass ? i_imem_rdata : (fifo_empty ? NOP : head_instr);
  assign o_instr_pc  = bypass ? resp_pc      : (fifo_empty ? '0  : head_pc);

  assign accept = o_instr_vld & i_instr_rdy & ~i_redirect;
  assign pop    = accept & ~fifo_empty;
  assign push   = resp_cur & ~i_redirect & ~(bypass & i_instr_rdy);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else if (i_redirect) begin
      // A current-stream response consumed now is discarded outright, not counted as stale.
      fetch_pc    <= {i_redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt    <= drop_cnt - cnt_t'(resp_drop) + outstanding - cnt_t'(resp_cur);
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + cnt_t'(grant) - cnt_t'(resp_cur);
      drop_cnt    <= drop_cnt - cnt_t'(resp_drop);
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (grant)    tag_wr <= tag_wr + 1'b1;
      if (resp_cur) tag_rd <= tag_rd + 1'b1;
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_q[wr_ptr[AW-1:0]] <= i_imem_rdata;
      pc_q[wr_ptr[AW-1:0]]    <= resp_pc;
    end
    if (grant) tag_q[tag_wr[AW-1:0]] <= fetch_pc;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_debug <= '0;
      insn_vld <= 1'b0;
    end else begin
      insn_vld <= accept;
      if (accept) pc_debug <= o_instr_pc;
    end
  end

  assign o_pc_debug = pc_debug;
  assign o_insn_vld = insn_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: startup vector table, scripted corner cases and a
// randomized run against a stream-level model (expected PC sequence per redirect epoch).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gnt = 1'b0, rvld = 1'b0, redirect = 1'b0, rdy = 1'b0;
  logic [31:0] rdata = '0, redirect_pc = '0;
  logic        imem_req, instr_vld, insn_vld;
  logic [31:0] imem_addr, instr, instr_pc, pc_debug;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(reset),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
    .i_imem_rvld(rvld), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_vld(instr_vld), .o_instr(instr), .o_instr_pc(instr_pc), .i_instr_rdy(rdy),
    .o_pc_debug(pc_debug), .o_insn_vld(insn_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    bit          gnt;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    bit          insn;
    logic [31:0] dbg;
  } vec_t;

  mreq_t       mq[$];
  int          passed = 0, total = 0;
  int          cyc = 0, lat = 1, epoch = 0, buffered = 0;
  logic [31:0] exp_fetch = RESET_PC, exp_dec = RESET_PC, prev_pc = '0;
  bit          prev_accept = 1'b0, s_grant = 1'b0, s_accept = 1'b0;
  vec_t        vecs[10];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive inputs, serve memory, then compare against the stream model.
  task automatic cycle(input bit rst, input bit g, input bit r, input bit rd, input logic [31:0] rpc);
    mreq_t m;
    int    pending0, buf0;
    bit    resp_cur, exp_vld;
    @(negedge clk);
    pending0    = mq.size();
    buf0        = buffered;
    reset       = rst;
    gnt         = g;
    rdy         = r;
    redirect    = rd;
    redirect_pc = rpc;
    resp_cur    = 1'b0;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      m        = mq.pop_front();
      rvld     = 1'b1;
      rdata    = word(m.addr);
      resp_cur = (m.epoch == epoch) && !rd;
    end else begin
      rvld  = 1'b0;
      rdata = $urandom;
    end
    #1;
    if (rst) begin
      check("req_in_reset", imem_req, 1'b0);
      mq.delete();
      buffered    = 0;
      epoch++;
      exp_fetch   = RESET_PC;
      exp_dec     = RESET_PC;
      prev_accept = 1'b0;
      s_grant     = 1'b0;
      s_accept    = 1'b0;
    end else begin
      check("req", imem_req, !rd && (pending0 + buf0 < DEPTH));
      exp_vld = (buf0 > 0) || (BYPASS && resp_cur);
      check("instr_vld", instr_vld, exp_vld);
      if (!instr_vld) begin
        check("nop_instr", instr, NOP);
        check("nop_pc", instr_pc, 32'h0);
      end
      s_grant = imem_req && g;
      if (s_grant) begin
        check("fetch_addr", imem_addr, exp_fetch);
        mq.push_back('{imem_addr, cyc + lat, epoch});
        exp_fetch += 32'd4;
      end
      check("insn_vld", insn_vld, prev_accept);
      if (prev_accept) check("pc_debug", pc_debug, prev_pc);
      s_accept = instr_vld && r && !rd;
      if (s_accept) begin
        check("dec_pc", instr_pc, exp_dec);
        check("dec_instr", instr, word(exp_dec));
        prev_pc = exp_dec;
        exp_dec += 32'd4;
      end
      prev_accept = s_accept;
      buffered = buf0 + (resp_cur ? 1 : 0) - (s_accept ? 1 : 0);
      if (rd) begin
        epoch++;
        buffered  = 0;
        exp_fetch = {rpc[31:2], 2'b00};
        exp_dec   = exp_fetch;
      end
      check("in_flight_bound", (mq.size() + buffered <= DEPTH), 1'b1);
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          grants, lat0, found;
    logic [31:0] a0, last_pc;

    // Startup stream: gnt=1, 1-cycle memory, rdy=1.
    lat0 = BYPASS ? 1 : 2;
    for (int k = 0; k < 10; k++) begin
      vecs[k].gnt  = 1'b1;
      vecs[k].rdy  = 1'b1;
      vecs[k].req  = 1'b1;
      vecs[k].addr = RESET_PC + 32'(4 * k);
      vecs[k].vld  = (k >= lat0);
      vecs[k].pc   = (k >= lat0) ? RESET_PC + 32'(4 * (k - lat0)) : 32'h0;
      vecs[k].insn = (k >= lat0 + 1);
      vecs[k].dbg  = (k >= lat0 + 1) ? RESET_PC + 32'(4 * (k - lat0 - 1)) : 32'h0;
    end

    lat = 1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, vecs[k].gnt, vecs[k].rdy, 1'b0, '0);
      check("tbl_req", imem_req, vecs[k].req);
      check("tbl_addr", imem_addr, vecs[k].addr);
      check("tbl_vld", instr_vld, vecs[k].vld);
      check("tbl_pc", instr_pc, vecs[k].pc);
      check("tbl_insn_vld", insn_vld, vecs[k].insn);
      check("tbl_pc_debug", pc_debug, vecs[k].dbg);
    end

    // Backpressure from empty: exactly DEPTH grants, then request stalls.
    do_reset();
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
      grants += s_grant ? 1 : 0;
    end
    check("bp_grants", grants, DEPTH);
    check("bp_req_stalled", imem_req, 1'b0);
    check("bp_vld", instr_vld, 1'b1);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Grant withheld: address holds.
    a0 = exp_fetch;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("hold_addr", imem_addr, a0);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("hold_release_grant", s_grant, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Latency 3, redirect with two requests outstanding.
    do_reset();
    lat = 3;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("two_outstanding", mq.size(), 2);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2000);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("rd_vld_t1", instr_vld, 1'b0);
    check("rd_req_t1", imem_req, 1'b1);
    check("rd_addr_t1", imem_addr, 32'h0000_2000);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
      if (s_accept) begin
        found = 1;
        check("rd_first_pc", instr_pc, 32'h0000_2000);
      end
    end
    if (found == 0) check("rd_first_accept_timeout", 32'h0, 32'h1);

    // Redirect to an unaligned target in the same cycle as a pop and a response.
    lat = 1;
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    last_pc = prev_pc;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3003);
    check("rp_vld_at_t", instr_vld, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("rp_vld_t1", instr_vld, 1'b0);
    check("rp_addr_t1", imem_addr, 32'h0000_3000);
    check("rp_insn_vld_t1", insn_vld, 1'b0);
    check("rp_pc_debug_t1", pc_debug, last_pc);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Reset mid-stream with buffered words and outstanding requests.
    lat = 3;
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("mr_vld", instr_vld, 1'b0);
    check("mr_instr", instr, NOP);
    check("mr_pc", instr_pc, 32'h0);
    check("mr_pc_debug", pc_debug, 32'h0);
    check("mr_insn_vld", insn_vld, 1'b0);
    check("mr_req", imem_req, 1'b1);
    check("mr_addr", imem_addr, RESET_PC);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic.
    for (int seg = 0; seg < 8; seg++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 2) == 0) do_reset();
      for (int k = 0; k < 300; k++)
        cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 29) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
